// File: rtl/uart_mem_loader.sv
// Packs UART bytes big-endian into 32-bit words and writes them to consecutive word addresses.
// Define LOADER_CHECKSUM_EN to add a modulo-256 byte checksum of the current load on o_checksum.
module uart_mem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    input  logic                  i_clear,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_mem_we,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic [7:0]            o_checksum
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            state_q, state_d;
    logic                  vld_dly_q, clr_dly_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  full_q, full_d;
    logic                  pend_q, pend_d;
    logic                  final_q, final_d;
    logic                  byte_edge, clr_edge, start;

    // Lower bytes are zeroed on every capture so a partial word is zero-filled.
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        case (idx)
            2'd0:    put_byte = {b, 24'h0};
            2'd1:    put_byte = {word[31:24], b, 16'h0};
            2'd2:    put_byte = {word[31:16], b, 8'h0};
            default: put_byte = {word[31:8], b};
        endcase
    endfunction

    assign byte_edge = i_byte_valid & ~vld_dly_q;
    assign clr_edge  = i_clear & ~clr_dly_q;
    assign start     = byte_edge && (state_q == IDLE || state_q == DONE ||
                                     (state_q == WRITE && final_q));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        full_d  = full_q;
        pend_d  = pend_q;
        final_d = final_q;
        case (state_q)
            COLLECT: begin
                if (byte_edge) begin
                    word_d = put_byte(word_q, idx_q, i_byte);
                    idx_d  = idx_q + 2'd1;
                    pend_d = pend_q | clr_edge;
                    if (idx_q == 2'd3) state_d = WRITE;
                end else if (clr_edge || pend_q) begin
                    pend_d = 1'b0;
                    if (idx_q == 2'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                        final_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // Once the top address has been written, further words are dropped.
                if (!full_q) begin
                    count_d = count_q + CNT_ONE;
                    if (addr_q == ADDR_MAX) full_d = 1'b1;
                    else                    addr_d = addr_q + ADDR_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
                idx_d   = 2'd0;
                final_d = 1'b0;
                state_d = final_q ? DONE : COLLECT;
                if (clr_edge) pend_d = 1'b1;
                if (byte_edge && !final_q) begin
                    word_d = put_byte(word_q, 2'd0, i_byte);
                    idx_d  = 2'd1;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_d = COLLECT;
            addr_d  = BASE;
            word_d  = put_byte(word_q, 2'd0, i_byte);
            idx_d   = 2'd1;
            count_d = '0;
            ovf_d   = 1'b0;
            full_d  = 1'b0;
            pend_d  = clr_edge;
            final_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            vld_dly_q <= 1'b0;
            clr_dly_q <= 1'b0;
            addr_q    <= BASE;
            word_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            pend_q    <= 1'b0;
            final_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_dly_q <= i_byte_valid;
            clr_dly_q <= i_clear;
            addr_q    <= addr_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            pend_q    <= pend_d;
            final_q   <= final_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Every byte edge is captured somewhere, so the sum follows byte edges directly.
    always_comb begin
        sum_d = sum_q;
        if (start)          sum_d = i_byte;
        else if (byte_edge) sum_d = sum_q + i_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign o_checksum = sum_q;
`else
    assign o_checksum = 8'h00;
`endif

    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = word_q;
    assign o_mem_we     = (state_q == WRITE) && !full_q;
    assign o_busy       = (state_q == COLLECT) || (state_q == WRITE);
    assign o_load_done  = (state_q == DONE);
    assign o_overflow   = ovf_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized bench for uart_mem_loader against a byte-list reference model of each load.
module tb_uart_mem_loader;

    localparam int AW   = 2;
    localparam int BASE = 0;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [7:0]    i_byte = 8'h00;
    logic          i_byte_valid = 1'b0;
    logic          i_clear = 1'b0;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_we;
    logic          o_busy;
    logic          o_load_done;
    logic          o_overflow;
    logic [AW:0]   o_word_count;
    logic [7:0]    o_checksum;

    uart_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .i_clear      (i_clear),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_we     (o_mem_we),
        .o_busy       (o_busy),
        .o_load_done  (o_load_done),
        .o_overflow   (o_overflow),
        .o_word_count (o_word_count),
        .o_checksum   (o_checksum)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  stim[$];
    logic [7:0]  pre[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge i_clk) begin
        if (i_rst_n && o_mem_we) begin
            wa_q.push_back(int'(o_mem_addr));
            wd_q.push_back(o_mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Drive stim (pre holds bytes already captured), close the load, and compare with the model.
    task automatic run_load(input string tag, input bit clr_last, input int hold);
        logic [7:0]  all[$];
        int          n, nw, exp_cnt, w;
        logic        exp_ovf;
        logic [7:0]  sum;
        logic [31:0] word;
        int          exp_a[$];
        logic [31:0] exp_d[$];

        all = {pre, stim};
        foreach (stim[i]) begin
            i_byte       = stim[i];
            i_byte_valid = 1'b1;
            if (clr_last && i == stim.size() - 1) i_clear = 1'b1;
            tick(hold > 0 ? hold : int'($urandom_range(1, 3)));
            i_byte_valid = 1'b0;
            i_clear      = 1'b0;
            tick(int'($urandom_range(1, 3)));
        end
        if (!clr_last) begin
            i_clear = 1'b1;
            tick(1);
            i_clear = 1'b0;
        end
        w = 0;
        while (!o_load_done && w < 20) begin
            tick(1);
            w++;
        end
        chk({tag, "_done"}, o_load_done, 1);
        tick(1);

        n = all.size();
        nw = (n + 3) / 4;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        sum = 8'h00;
        foreach (all[i]) sum = sum + all[i];
        for (int k = 0; k < nw; k++) begin
            word = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < n) word[31 - 8 * b -: 8] = all[4 * k + b];
            if (k < (1 << AW) - BASE) begin
                exp_a.push_back(BASE + k);
                exp_d.push_back(word);
                exp_cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end

        chk({tag, "_nwrites"}, wa_q.size(), exp_cnt);
        for (int k = 0; k < exp_cnt && k < wa_q.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wa_q[k], exp_a[k]);
            chk($sformatf("%s_data%0d", tag, k), wd_q[k], exp_d[k]);
        end
        chk({tag, "_count"}, o_word_count, exp_cnt);
        chk({tag, "_ovf"}, o_overflow, exp_ovf);
        chk({tag, "_busy"}, o_busy, 0);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_csum"}, o_checksum, sum);
`else
        chk({tag, "_csum"}, o_checksum, 0);
`endif
        wa_q.delete();
        wd_q.delete();
        pre.delete();
        stim.delete();
    endtask

    initial begin
        tick(2);
        chk("rst_we", o_mem_we, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_load_done, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_count", o_word_count, 0);
        chk("rst_addr", o_mem_addr, BASE);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_csum", o_checksum, 0);
        i_rst_n = 1'b1;
        tick(2);
        chk("idle_done", o_load_done, 0);

        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load("two_words", 1'b0, 0);

        stim = '{8'hAA, 8'hBB};
        run_load("partial", 1'b0, 0);

        i_clear = 1'b1;
        tick(1);
        i_clear = 1'b0;
        tick(3);
        chk("clr_in_done_done", o_load_done, 1);
        chk("clr_in_done_nwr", wa_q.size(), 0);

        stim = '{8'h55};
        run_load("hold20", 1'b0, 20);

        for (int i = 0; i < 20; i++) stim.push_back(8'($urandom));
        run_load("overflow", 1'b0, 0);

        stim = '{8'h01};
        run_load("same_cycle", 1'b1, 0);

        stim = '{8'hFF, 8'h02};
        run_load("csum", 1'b0, 0);

        i_byte = 8'hC1; i_byte_valid = 1'b1; tick(1);
        i_byte_valid = 1'b0; tick(1);
        i_byte = 8'hC2; i_byte_valid = 1'b1; tick(1);
        i_byte_valid = 1'b0; tick(1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_count", o_word_count, 0);
        chk("midrst_addr", o_mem_addr, BASE);
        i_byte = 8'h77;
        i_byte_valid = 1'b1;
        tick(1);
        i_rst_n = 1'b1;
        tick(1);
        chk("rel_edge_busy", o_busy, 1);
        i_byte_valid = 1'b0;
        tick(1);
        pre  = '{8'h77};
        stim = '{8'h88, 8'h99, 8'hAA};
        run_load("after_rst", 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = int'($urandom_range(1, 22));
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), $urandom_range(0, 3) == 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width of o_mem_addr.
REQ-002 Parameter BASE_ADDR, default 0, SHALL set the first word address written per load.
REQ-003 i_clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_byte  input  8  received byte from the UART receiver.
REQ-006 i_byte_valid  input  1  level; a new byte SHALL be signalled only by its 0->1 transition.
REQ-007 i_clear  input  1  level; receiver idle timeout; only its 0->1 transition SHALL be acted on.
REQ-008 o_mem_addr  output  ADDR_WIDTH  word address for the memory write.
REQ-009 o_mem_wdata  output  32  assembled word.
REQ-010 o_mem_we  output  1  one-cycle write strobe; memory always accepts.
REQ-011 o_busy  output  1  high in COLLECT and WRITE.
REQ-012 o_load_done  output  1  high in DONE.
REQ-013 o_overflow  output  1  sticky; set when a word is dropped at address wrap.
REQ-014 o_word_count  output  ADDR_WIDTH+1  words written in the current load.
REQ-015 o_checksum  output  8  byte checksum, see Configuration.

Function
REQ-016 Edge detection SHALL use one registered copy each of i_byte_valid and i_clear; an edge is current input high and registered copy low.
REQ-017 The FSM SHALL have states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE/DONE: a byte edge SHALL begin a load: address = BASE_ADDR, word_count = 0, overflow cleared, byte captured as byte 0, go to COLLECT.
REQ-019 COLLECT: each byte edge SHALL capture the byte big-endian (byte 0 -> bits 31:24, byte 3 -> bits 7:0) and increment a 2-bit byte index.
REQ-020 On capture of byte 3, the FSM SHALL go to WRITE; o_mem_we SHALL be high exactly in the following cycle with the completed word and the current address.
REQ-021 WRITE SHALL last one cycle, after which the address increments by 1, word_count by 1, byte index resets to 0, and the FSM returns to COLLECT.
REQ-022 A byte edge arriving in the WRITE cycle SHALL be captured as byte 0 of the next word, not lost.
REQ-023 Clear edge in COLLECT with byte index 0 SHALL go directly to DONE with no write.
REQ-024 Clear edge in COLLECT with byte index 1-3 SHALL write the partial word with unfilled low bytes zero (one WRITE cycle, word_count incremented), then go to DONE.
REQ-025 Byte edge and clear edge in the same cycle: the byte SHALL be captured first; the clear SHALL be held pending and acted on in the next COLLECT cycle.
REQ-026 A clear edge in IDLE or DONE SHALL be ignored.
REQ-027 If the address equals 2^ADDR_WIDTH-1 and that word has been written, subsequent words SHALL NOT assert o_mem_we, SHALL set o_overflow, and SHALL NOT increment word_count.
REQ-028 DONE SHALL hold o_load_done high until the next byte edge.

Reset
REQ-029 On i_rst_n low the FSM SHALL go to IDLE and all outputs SHALL be 0, with o_mem_addr = BASE_ADDR.
REQ-030 Reset mid-load SHALL discard any partial word with no write; edge registers SHALL reset to 0, so an input already high at release SHALL count as an edge.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN: when defined, o_checksum SHALL be the modulo-256 sum of all bytes captured in the current load, cleared at load start; when undefined, o_checksum SHALL be tied to 0 with no adder logic.

Verification
REQ-032 Send bytes 12 34 56 78 9A BC DE F0, then clear -> writes 0x12345678@0 and 0x9ABCDEF0@1, o_word_count=2, o_load_done=1.
REQ-033 Send AA BB, then clear -> single write 0xAABB0000@0, then DONE.
REQ-034 Hold i_byte_valid high for 20 cycles with one byte 0x55 -> exactly one byte captured.
REQ-035 ADDR_WIDTH=2, 5 words -> writes at addresses 0-3, 5th dropped, o_overflow=1, o_word_count=4.
REQ-036 Byte edge 0x01 and clear edge in the same cycle with byte index 0 -> write 0x01000000@0, then DONE.
REQ-037 With LOADER_CHECKSUM_EN, bytes FF 02 -> o_checksum=0x01; without the macro -> o_checksum=0x00.
